// File: rtl/e_mdu_if.sv
// Pipeline-side bundle of the E-stage multiply/divide unit: op issue, operands,
// stall handshake and HI/LO read-back.
interface e_mdu_if;
  logic        E_start;
  logic [3:0]  E_mdu_op;
  logic [31:0] E_V1;
  logic [31:0] E_V2;
  logic        E_busy;
  logic        E_stall_req;
  logic [31:0] E_mdu_out;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  modport master (
    output E_start, E_mdu_op, E_V1, E_V2,
    input  E_busy, E_stall_req, E_mdu_out, E_HI, E_LO
  );

  modport slave (
    input  E_start, E_mdu_op, E_V1, E_V2,
    output E_busy, E_stall_req, E_mdu_out, E_HI, E_LO
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs fixed-latency MULT/DIV with a busy
// handshake. Define MDU_MADD_EN to add MADD/MADDU multiply-accumulate.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10
  } op_e;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  op_e              op;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      pend_hi_q, pend_lo_q;
  logic             pend_we_q;

  logic [31:0]      pend_hi_d, pend_lo_d;
  logic             pend_we_d;
  logic             go_d;
  logic [CNT_W-1:0] cnt_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] div_b_s, div_b_u;
  logic signed [31:0] quot_s, rem_s;
  logic        [31:0] quot_u, rem_u;

  assign op = op_e'(bus.E_mdu_op);

  assign prod_s = $signed({{32{bus.E_V1[31]}}, bus.E_V1}) * $signed({{32{bus.E_V2[31]}}, bus.E_V2});
  assign prod_u = {32'd0, bus.E_V1} * {32'd0, bus.E_V2};

  // Substituting a divisor of 1 covers divide-by-zero (result discarded) and
  // 0x80000000 / -1, whose defined answer is exactly the dividend with remainder 0.
  assign div_b_s = ((bus.E_V2 == 32'd0) ||
                    (bus.E_V1 == 32'h8000_0000 && bus.E_V2 == 32'hFFFF_FFFF)) ? 32'd1 : bus.E_V2;
  assign div_b_u = (bus.E_V2 == 32'd0) ? 32'd1 : bus.E_V2;
  assign quot_s  = $signed(bus.E_V1) / $signed(div_b_s);
  assign rem_s   = $signed(bus.E_V1) % $signed(div_b_s);
  assign quot_u  = bus.E_V1 / div_b_u;
  assign rem_u   = bus.E_V1 % div_b_u;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    go_d      = 1'b0;
    pend_we_d = 1'b0;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = CNT_W'(MULT_CYCLES);
    case (op)
      OP_MULT:  begin go_d = 1'b1; pend_we_d = 1'b1; {pend_hi_d, pend_lo_d} = prod_s; end
      OP_MULTU: begin go_d = 1'b1; pend_we_d = 1'b1; {pend_hi_d, pend_lo_d} = prod_u; end
      OP_DIV: begin
        go_d      = 1'b1;
        cnt_d     = CNT_W'(DIV_CYCLES);
        pend_we_d = (bus.E_V2 != 32'd0);
        pend_hi_d = rem_s;
        pend_lo_d = quot_s;
      end
      OP_DIVU: begin
        go_d      = 1'b1;
        cnt_d     = CNT_W'(DIV_CYCLES);
        pend_we_d = (bus.E_V2 != 32'd0);
        pend_hi_d = rem_u;
        pend_lo_d = quot_u;
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        go_d      = 1'b1;
        pend_we_d = 1'b1;
        {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
      end
      OP_MADDU: begin
        go_d      = 1'b1;
        pend_we_d = 1'b1;
        {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_u;
      end
`endif
      default: ;
    endcase
  end

  // NOTE: the pending result registers are reset too, so an aborted op leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        S_IDLE: begin
          if (bus.E_start && go_d) begin
            state_q   <= S_BUSY;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
          end else if (op == OP_MTHI) begin
            hi_q <= bus.E_V1;
          end else if (op == OP_MTLO) begin
            lo_q <= bus.E_V1;
          end
        end
        S_BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            if (pend_we_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.E_busy      = (state_q == S_BUSY);
  assign bus.E_stall_req = bus.E_busy | bus.E_start;
  assign bus.E_HI        = hi_q;
  assign bus.E_LO        = lo_q;
  assign bus.E_mdu_out   = (op == OP_MFHI) ? hi_q :
                           (op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: reset, MULT/DIV arithmetic and latency, MT writes,
// ignored starts while busy, async abort, and the MDU_MADD_EN option.
module tb_e_mdu;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic start, input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2);
    bus.E_start  = start;
    bus.E_mdu_op = op;
    bus.E_V1     = v1;
    bus.E_V2     = v2;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2);
    drive(1'b1, op, v1, v2);
    tick();
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    drive(1'b0, op, v, 32'd0);
    tick();
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
  endtask

  // Counts busy cycles after the start edge, bounded so a stuck unit still ends.
  task automatic busy_len(output int n);
    n = 0;
    while (bus.E_busy && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    check({tag, "_hi"}, 64'(bus.E_HI), 64'(hi));
    check({tag, "_lo"}, 64'(bus.E_LO), 64'(lo));
  endtask

  int n;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    repeat (3) tick();
    check("rst_busy", 64'(bus.E_busy), 64'd0);
    bus.E_start = 1'b1;
    #1 check("rst_stall_follows_start", 64'(bus.E_stall_req), 64'd1);
    bus.E_start = 1'b0;
    #1 check("rst_stall_low", 64'(bus.E_stall_req), 64'd0);
    reset = 1'b1;
    tick();

    drive(1'b0, OP_MFHI, 32'd0, 32'd0);
    #1 check("mfhi_after_reset", 64'(bus.E_mdu_out), 64'd0);
    drive(1'b0, OP_MFLO, 32'd0, 32'd0);
    #1 check("mflo_after_reset", 64'(bus.E_mdu_out), 64'd0);
    check("busy_after_reset", 64'(bus.E_busy), 64'd0);
    drive(1'b0, OP_NONE, 32'd0, 32'd0);

    // MULT -2 * 3 = -6
    drive(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3);
    #1 check("stall_on_start", 64'(bus.E_stall_req), 64'd1);
    tick();
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    check("stall_while_busy", 64'(bus.E_stall_req), 64'd1);
    busy_len(n);
    check("mult_busy_len", 64'(n), 64'd5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    drive(1'b0, OP_MFLO, 32'd0, 32'd0);
    #1 check("mflo_mult", 64'(bus.E_mdu_out), 64'hFFFF_FFFA);
    drive(1'b0, OP_MFHI, 32'd0, 32'd0);
    #1 check("mfhi_mult", 64'(bus.E_mdu_out), 64'hFFFF_FFFF);
    drive(1'b0, OP_MTHI, 32'd0, 32'd0);
    #1 check("mdu_out_zero_other_op", 64'(bus.E_mdu_out), 64'd0);
    drive(1'b0, OP_NONE, 32'd0, 32'd0);

    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    busy_len(n);
    check("multu_busy_len", 64'(n), 64'd5);
    check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    // DIV -7 / 2: q=-3, r=-1
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    busy_len(n);
    check("div_busy_len", 64'(n), 64'd10);
    check_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIV 7 / -2: q=-3, r=+1
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    busy_len(n);
    check_hilo("div_negdivisor", 32'h0000_0001, 32'hFFFF_FFFD);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_len(n);
    check_hilo("div_overflow", 32'h0000_0000, 32'h8000_0000);

    issue(OP_DIVU, 32'd100, 32'd7);
    busy_len(n);
    check_hilo("divu", 32'd2, 32'd14);

    // DIVU by zero keeps HI/LO
    mt(OP_MTHI, 32'h11);
    mt(OP_MTLO, 32'h22);
    issue(OP_DIVU, 32'd7, 32'd0);
    busy_len(n);
    check("divu0_busy_len", 64'(n), 64'd10);
    check_hilo("divu0", 32'h11, 32'h22);

    drive(1'b0, OP_MTHI, 32'h1234, 32'd0);
    tick();
    check_hilo("mthi", 32'h1234, 32'h22);
    drive(1'b0, OP_MTLO, 32'h5678, 32'd0);
    tick();
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    check_hilo("mtlo", 32'h1234, 32'h5678);

    // Second start during BUSY must be ignored
    issue(OP_MULT, 32'd6, 32'd7);
    n = 0;
    while (bus.E_busy && n < 200) begin
      n++;
      if (n == 2) drive(1'b1, OP_MULT, 32'd100, 32'd100);
      else if (n == 3) drive(1'b0, OP_MTHI, 32'hDEAD, 32'd0);
      else drive(1'b0, OP_NONE, 32'd0, 32'd0);
      tick();
    end
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    check("restart_busy_len", 64'(n), 64'd5);
    check_hilo("restart", 32'd0, 32'd42);
    tick();
    check("no_second_op", 64'(bus.E_busy), 64'd0);

    // Async abort at busy cycle 3
    issue(OP_MULT, 32'd9, 32'd9);
    repeat (2) tick();
    check("abort_busy_before", 64'(bus.E_busy), 64'd1);
    #2 reset = 1'b0;
    #1 check("abort_busy_async", 64'(bus.E_busy), 64'd0);
    tick();
    reset = 1'b1;
    repeat (8) tick();
    check("abort_no_late_busy", 64'(bus.E_busy), 64'd0);
    check_hilo("abort", 32'd0, 32'd0);

    // Undefined op codes behave as NONE
    mt(OP_MTHI, 32'h11);
    mt(OP_MTLO, 32'h22);
    issue(4'd15, 32'd3, 32'd3);
    check("op15_no_busy", 64'(bus.E_busy), 64'd0);
    check_hilo("op15", 32'h11, 32'h22);

`ifdef MDU_MADD_EN
    mt(OP_MTHI, 32'd0);
    mt(OP_MTLO, 32'hFFFF_FFFF);
    issue(OP_MADDU, 32'd1, 32'd1);
    busy_len(n);
    check("maddu_busy_len", 64'(n), 64'd5);
    check_hilo("maddu", 32'd1, 32'd0);
    issue(OP_MADD, 32'hFFFF_FFFF, 32'd1);
    busy_len(n);
    check("madd_busy_len", 64'(n), 64'd5);
    check_hilo("madd", 32'd0, 32'hFFFF_FFFF);
`else
    issue(OP_MADD, 32'd5, 32'd5);
    check("madd_off_no_busy", 64'(bus.E_busy), 64'd0);
    check_hilo("madd_off", 32'h11, 32'h22);
    issue(OP_MADDU, 32'd5, 32'd5);
    check("maddu_off_no_busy", 64'(bus.E_busy), 64'd0);
    check_hilo("maddu_off", 32'h11, 32'h22);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
